// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// Recovers asynchronous frames (1 start bit, DATA_BITS data bits sent LSB first,
// 1 stop bit) from a serial line that the upstream 16x sampler has already
// synchronised. The sample tick comes from a local divider, so no tick wire
// crosses between stages. Each received byte is held in a valid/ready output
// register until downstream logic accepts it.
//
// Ports
//   clk_in         system clock; all logic runs on its rising edge
//   rst_n_in       synchronous active-low reset
//   sig_in         sampled serial line; idles high
//   ready_in       downstream accepts data_out this cycle
//   data_out       received byte; bit 0 is the first data bit on the line
//   valid_out      data_out holds a byte that has not been consumed yet
//   frame_err_out  1-cycle pulse: the stop bit was sampled low
//   overrun_out    1-cycle pulse: a new byte overwrote an unconsumed one
//   busy_out       high whenever the receiver is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a low sample on the line (start edge)
// START  | counting to the middle of the start bit to reject glitches
// DATA   | sampling each data bit at its middle, shifting in LSB first
// STOP   | sampling the middle of the stop bit, then committing or erroring
module uart_rx_framer #(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int SAMP_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 sig_in,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  localparam int DIV = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
  localparam int DW  = $clog2(DIV) + 1;
  localparam int SW  = $clog2(SAMP_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SCNT_MID  = SW'(SAMP_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [BW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, shift_nx;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   tick;
  logic                   byte_done;
  logic                   stop_bad;

  // Tick is high for the single cycle in which the down-counter sits at zero.
  assign tick = (div_q == '0);

  // State register: every flop in the block, with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      div_q   <= DIV_LAST;
      scnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Shift right: the new sample enters at the MSB, so after the last data
  // bit the first bit received ends up in bit 0.
  always_comb begin
    shift_nx = '0;
    shift_nx[DATA_BITS-1] = sig_in;
    for (int i = 0; i < DATA_BITS - 1; i++) begin
      shift_nx[i] = shift_q[i+1];
    end
  end

  // Next-state logic; the receiver only moves on tick cycles.
  always_comb begin
    div_d     = tick ? DIV_LAST : div_q - 1'b1;
    state_d   = state_q;
    scnt_d    = scnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!sig_in) begin
            state_d = S_START;
            scnt_d  = '0;
          end
        end
        S_START: begin
          if (scnt_q == SCNT_MID) begin
            scnt_d = '0;
            idx_d  = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_d = sig_in ? S_IDLE : S_DATA;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (scnt_q == SCNT_LAST) begin
            shift_d = shift_nx;
            scnt_d  = '0;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (scnt_q == SCNT_LAST) begin
            // Back to IDLE at mid stop bit so a back-to-back start edge is seen.
            state_d   = S_IDLE;
            scnt_d    = '0;
            byte_done = sig_in;
            stop_bad  = ~sig_in;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register logic. A byte landing in the same cycle as a transfer
  // refills the register without counting as an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
    if (byte_done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
    ferr_d = stop_bad;
    ovr_d  = byte_done & valid_q & ~ready_in;
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = ferr_q;
  assign overrun_out   = ovr_q;
  assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  uart_rx_framer #(
    .CLK_HZ      (160),
    .BAUD_RATE   (10),
    .SAMP_PER_BIT(16),
    .DATA_BITS   (8)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .sig_in       (sig),
    .ready_in     (ready),
    .data_out     (data),
    .valid_out    (valid),
    .frame_err_out(ferr),
    .overrun_out  (ovr),
    .busy_out     (busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int ferr_cyc = 0;
  int n_ovr = 0;
  int ovr_cyc = 0;
  int t_start = 0;
  int t_valid = 0;
  logic pv = 1'b0;
  logic pf = 1'b0;
  logic po = 1'b0;

  always @(posedge clk) cyc++;

  // Event monitor: counts rising edges and high cycles of the output flags.
  always @(negedge clk) begin
    if (valid === 1'b1 && pv !== 1'b1) begin
      n_valid++;
      t_valid = cyc;
    end
    if (ferr === 1'b1) begin
      ferr_cyc++;
      if (pf !== 1'b1) n_ferr++;
    end
    if (ovr === 1'b1) begin
      ovr_cyc++;
      if (po !== 1'b1) n_ovr++;
    end
    pv = valid;
    pf = ferr;
    po = ovr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    sig = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      sig = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  int v0, f0, fc0, o0, oc0;

  initial begin
    rst_n = 1'b0;
    sig   = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // Good frame, held until downstream is ready.
    f0 = n_ferr;
    o0 = n_ovr;
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_valid", valid, 1'b1);
    chk("a5_data", data, 8'hA5);
    chk("a5_latency", t_valid - t_start, 153);
    chk("a5_no_ferr", n_ferr - f0, 0);
    consume();
    chk("a5_taken", valid, 1'b0);
    chk("a5_no_ovr", n_ovr - o0, 0);

    // Start glitch of 3 clk.
    v0 = n_valid;
    f0 = n_ferr;
    sig = 1'b0;
    @(negedge clk);
    chk("glitch_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    sig = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_idle", busy, 1'b0);
    idle(200);
    chk("glitch_no_byte", n_valid - v0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);

    // Framing error, then a good frame.
    f0  = n_ferr;
    fc0 = ferr_cyc;
    v0  = n_valid;
    send_frame(8'h3C, 1'b0);
    idle(40);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_width", ferr_cyc - fc0, 1);
    chk("ferr_no_byte", n_valid - v0, 0);
    chk("ferr_valid", valid, 1'b0);
    send_frame(8'h11, 1'b1);
    idle(20);
    chk("x11_valid", valid, 1'b1);
    chk("x11_data", data, 8'h11);
    consume();
    chk("x11_taken", valid, 1'b0);

    // Back-to-back frames with nobody consuming.
    o0  = n_ovr;
    oc0 = ovr_cyc;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle(20);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_width", ovr_cyc - oc0, 1);
    chk("ovr_data", data, 8'h02);
    chk("ovr_valid", valid, 1'b1);

    // Reset in the middle of an 0xFF frame, with 0x02 still unconsumed.
    v0 = n_valid;
    sig = 1'b0;
    repeat (16) @(negedge clk);
    sig = 1'b1;
    repeat (40) @(negedge clk);
    chk("ff_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ferr", ferr, 1'b0);
    chk("mid_rst_ovr", ovr, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (130) @(negedge clk);
    idle(20);
    chk("ff_no_byte", n_valid - v0, 0);
    chk("ff_valid", valid, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("x5a_valid", valid, 1'b1);
    chk("x5a_data", data, 8'h5A);
    chk("x5a_bytes", n_valid - v0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
